correlator_scheduler: RTL
=========================

// Module: correlator_scheduler
// PURPOSE
//  Timing and readout controller for the correlator datapath: divides clk into sample strobes and
//  integration boundaries, commands the datapath to snapshot and clear its lag accumulators, then
//  streams the snapshot out as a framed byte stream to the UART transmitter.
//  Sits between the correlator core (accumulator shadow bank) and the UART TX byte interface.
// PARAMETERS
//  SAMPLE_DIV          50       clk cycles per sample strobe (>=2)
//  INTEGRATION_SAMPLES 1000000  sample strobes per integration period (>=1)
//  NUM_CHANNELS        4000     accumulator words read out per frame (NUM_INPUTS*MAX_DELAY class)
//  RESOLUTION          32       accumulator width in bits (multiple of 8)
//  SYNC_BYTE           8'hA5    first byte of every frame
// PORTS
//  clk               in   1                  system clock (PLL output)
//  rst_n             in   1                  asynchronous active-low reset
//  enable            in   1                  1 = run sample/integration timers
//  sample_clk_pulse  out  1                  1-cycle sample strobe to datapath and pin
//  integration_clk_pulse out 1               1-cycle integration-boundary strobe
//  acc_snapshot      out  1                  1-cycle: datapath copies accumulators to shadow bank
//  acc_clear         out  1                  1-cycle: datapath zeroes live accumulators
//  rd_addr           out  $clog2(NUM_CHANNELS) shadow-bank read address
//  rd_data           in   RESOLUTION         shadow word, valid exactly 1 cycle after rd_addr
//  tx_data           out  8                  byte to UART TX
//  tx_valid          out  1                  byte valid; held with tx_data stable until tx_ready
//  tx_ready          in   1                  UART accepts byte when tx_valid&tx_ready
//  busy              out  1                  readout frame in progress
//  overrun           out  1                  sticky: boundary arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, frame_idx 0, FSM IDLE; overrun cleared only by reset.
//  Sample timer: scnt 0..SAMPLE_DIV-1 while enable; sample_clk_pulse=1 in cycle scnt==SAMPLE_DIV-1.
//  Integration: icnt counts strobes; on strobe with icnt==INTEGRATION_SAMPLES-1 icnt->0 and
//   integration_clk_pulse=acc_clear=1 same cycle as that strobe. acc_snapshot=1 same cycle iff !busy.
//  enable=0: scnt/icnt hold at current value, no strobes; an active readout runs to completion.
//  Readout FSM (leaves IDLE the cycle after acc_snapshot):
//   IDLE -> HDR: send SYNC_BYTE, then frame_idx[7:0]; frame_idx++ after frame end (wraps 255->0).
//   RD_REQ: drive rd_addr=ch; -> RD_WAIT (1 cycle) -> latch rd_data into shift reg -> SEND.
//   SEND: RESOLUTION/8 bytes, MSB byte first; each byte leaves on tx_valid&tx_ready.
//   after last byte: ch==NUM_CHANNELS-1 ? IDLE : ch++, RD_REQ.
//  busy=1 from HDR entry through acceptance of final byte; falls the cycle after.
//  tx_valid may stay high across consecutive bytes; never drops before handshake completes.
//  Boundary during busy: clear/integration strobes still fire, snapshot suppressed, overrun<=1,
//   frame_idx not incremented for the skipped frame (receiver detects gaps only via overrun).
//  Boundary in same cycle busy falls: busy considered 1 -> suppressed (deterministic).
//  Async reset mid-frame: frame abandoned, tx_valid drops immediately; next frame restarts with idx 0.
//  Frame length = 2 + NUM_CHANNELS*RESOLUTION/8 bytes; must fit in integration period at BAUD_RATE.
// STRUCTURE
//  Package correlator_pkg: SYNC_BYTE, FSM state enum {IDLE,HDR_SYNC,HDR_IDX,RD_REQ,RD_WAIT,SEND},
//   width helper for channel address.
//  Sub-module: correlator_timebase (scnt/icnt, strobes, enable hold); readout FSM in this module.
// TESTING  (SAMPLE_DIV=4, INTEGRATION_SAMPLES=3, NUM_CHANNELS=2, RESOLUTION=16, tx_ready=1)
//  Strobes: after reset, enable=1 -> sample pulse at cycles 3,7,11; integration/clear/snapshot at 11.
//  Frame: rd_data = 16'h1234 (ch0), 16'hABCD (ch1) -> bytes A5,00,12,34,AB,CD; busy low afterwards.
//  Backpressure: tx_ready toggled randomly -> same 6 bytes, tx_data stable while valid&!ready.
//  Overrun: tx_ready=0 across next boundary -> no acc_snapshot, overrun=1, next sent frame idx=01.
//  enable=0 at cycle 6 for 10 cycles -> no strobes; resumes from held scnt, next strobe cycle 17.
//  Reset asserted mid-SEND -> tx_valid=0, busy=0 same cycle; next frame idx byte 00.

Source files
------------

// File: rtl/correlator_pkg.sv
// correlator_pkg
//   Shared definitions for the correlator readout controller:
//   default frame sync byte, readout FSM state encoding and a width helper
//   for counters/addresses sized from an element count.
package correlator_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR_SYNC,
        HDR_IDX,
        RD_REQ,
        RD_WAIT,
        SEND
    } state_t;

    // Bits needed to index n elements; never narrower than 1 bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/correlator_timebase.sv
// correlator_timebase
//   Divides clk into sample strobes and counts strobes into integration
//   periods. Both counters freeze while enable is low, so timing resumes
//   exactly where it stopped.
//   Ports:
//     clk                in   system clock
//     rst_n              in   asynchronous active-low reset
//     enable             in   1 = counters run
//     sample_pulse       out  1-cycle strobe in the last cycle of each sample
//     integration_pulse  out  1-cycle strobe coincident with the last sample
//                             strobe of each integration period
module correlator_timebase
    import correlator_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV          = 50,
    parameter int unsigned INTEGRATION_SAMPLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic sample_pulse,
    output logic integration_pulse
);

    localparam int unsigned SW = addr_width(SAMPLE_DIV);
    localparam int unsigned IW = addr_width(INTEGRATION_SAMPLES);
    localparam logic [SW-1:0] SCNT_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [IW-1:0] ICNT_LAST = IW'(INTEGRATION_SAMPLES - 1);

    logic [SW-1:0] scnt;
    logic [IW-1:0] icnt;

    // Strobes are decoded from the counters gated by enable so that a
    // held counter sitting on its terminal value emits nothing.
    assign sample_pulse      = enable && (scnt == SCNT_LAST);
    assign integration_pulse = sample_pulse && (icnt == ICNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            icnt <= '0;
        end else if (enable) begin
            if (scnt == SCNT_LAST) begin
                scnt <= '0;
            end else begin
                scnt <= scnt + 1'b1;
            end
            if (sample_pulse) begin
                if (icnt == ICNT_LAST) begin
                    icnt <= '0;
                end else begin
                    icnt <= icnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/correlator_scheduler.sv
// correlator_scheduler
//   Timing and readout controller for the correlator datapath. Generates
//   sample/integration strobes, commands accumulator snapshot/clear, then
//   streams the shadow bank out as a framed byte stream:
//     SYNC_BYTE, frame_idx[7:0], then per channel RESOLUTION/8 bytes MSB first.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     enable                 1 = run sample/integration timers
//     sample_clk_pulse       1-cycle sample strobe
//     integration_clk_pulse  1-cycle integration-boundary strobe
//     acc_snapshot           1-cycle: copy accumulators to shadow bank
//     acc_clear              1-cycle: zero live accumulators
//     rd_addr / rd_data      shadow-bank read port (data 1 cycle after addr)
//     tx_data/tx_valid/tx_ready  byte stream to UART TX (valid/ready)
//     busy                   readout frame in progress
//     overrun                sticky: boundary arrived while busy
module correlator_scheduler
    import correlator_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV          = 50,
    parameter int unsigned INTEGRATION_SAMPLES = 1000000,
    parameter int unsigned NUM_CHANNELS        = 4000,
    parameter int unsigned RESOLUTION          = 32,
    parameter logic [7:0]  SYNC_BYTE           = SYNC_BYTE_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    output logic                                  sample_clk_pulse,
    output logic                                  integration_clk_pulse,
    output logic                                  acc_snapshot,
    output logic                                  acc_clear,
    output logic [addr_width(NUM_CHANNELS)-1:0]   rd_addr,
    input  logic [RESOLUTION-1:0]                 rd_data,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int unsigned AW         = addr_width(NUM_CHANNELS);
    localparam int unsigned NUM_BYTES  = RESOLUTION / 8;
    localparam int unsigned BW         = addr_width(NUM_BYTES);
    localparam logic [AW-1:0] LAST_CH  = AW'(NUM_CHANNELS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

    logic                  sample_pulse;
    logic                  integration_pulse;
    state_t                state;
    logic [7:0]            frame_idx;
    logic [RESOLUTION-1:0] shift;
    logic [BW-1:0]         byte_cnt;
    logic                  tx_fire;

    correlator_timebase #(
        .SAMPLE_DIV          (SAMPLE_DIV),
        .INTEGRATION_SAMPLES (INTEGRATION_SAMPLES)
    ) u_timebase (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .sample_pulse      (sample_pulse),
        .integration_pulse (integration_pulse)
    );

    assign sample_clk_pulse      = sample_pulse;
    assign integration_clk_pulse = integration_pulse;
    assign acc_clear             = integration_pulse;
    // busy is the registered flag, so a boundary landing in the cycle the
    // last byte is accepted still sees busy=1 and is suppressed.
    assign acc_snapshot          = integration_pulse && !busy;
    assign tx_fire               = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            rd_addr   <= '0;
            frame_idx <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
        end else begin
            if (integration_pulse && busy) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (acc_snapshot) begin
                        state    <= HDR_SYNC;
                        busy     <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        rd_addr  <= '0;
                    end
                end

                HDR_SYNC: begin
                    if (tx_fire) begin
                        tx_data <= frame_idx;
                        state   <= HDR_IDX;
                    end
                end

                HDR_IDX: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state    <= RD_REQ;
                    end
                end

                // rd_addr already holds the channel; this cycle presents it.
                RD_REQ: begin
                    state <= RD_WAIT;
                end

                // Top byte goes straight to tx_data; the rest waits in shift,
                // left-aligned so every later byte comes from the same slice.
                RD_WAIT: begin
                    tx_data  <= rd_data[RESOLUTION-1 -: 8];
                    shift    <= rd_data << 8;
                    byte_cnt <= '0;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end

                SEND: begin
                    if (tx_fire) begin
                        if (byte_cnt == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            if (rd_addr == LAST_CH) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                frame_idx <= frame_idx + 8'd1;
                                rd_addr   <= '0;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                state   <= RD_REQ;
                            end
                        end else begin
                            tx_data  <= shift[RESOLUTION-1 -: 8];
                            shift    <= shift << 8;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
